// File: rtl/acc_sequencer_if.sv
// Purpose: bundles the program-load, run-control and accumulator-drive signals of acc_sequencer.
// Latency: none, wires only.
// Backpressure: none; the sequencer ignores start/prog_we while busy.
// Ports: master = control/test side (drives program and run requests),
//        slave  = sequencer side (drives busy/done/pc and the accumulator controls).
// Build option ACC_SEQ_AUTOCLR_EN adds acc_clr_n (active-low accumulator clear).
interface acc_sequencer_if #(
    parameter int AW = 3
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [3:0]    prog_a;
    logic [3:0]    prog_op;
    logic          start;
    logic [AW:0]   len;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
    logic [3:0]    acc_a;
    logic [8:0]    acc_in;
    logic          acc_en;
`ifdef ACC_SEQ_AUTOCLR_EN
    logic          acc_clr_n;

    modport master (
        output prog_we, prog_addr, prog_a, prog_op, start, len, abort,
        input  busy, done, pc, acc_a, acc_in, acc_en, acc_clr_n
    );
    modport slave (
        input  prog_we, prog_addr, prog_a, prog_op, start, len, abort,
        output busy, done, pc, acc_a, acc_in, acc_en, acc_clr_n
    );
`else
    modport master (
        output prog_we, prog_addr, prog_a, prog_op, start, len, abort,
        input  busy, done, pc, acc_a, acc_in, acc_en
    );
    modport slave (
        input  prog_we, prog_addr, prog_a, prog_op, start, len, abort,
        output busy, done, pc, acc_a, acc_in, acc_en
    );
`endif
endinterface

// File: rtl/acc_sequencer.sv
// Purpose: program sequencer for the 4-bit signed accumulator; stores (operand, op) entries, replays them on start.
// Latency: first op issues 1 cycle after the start edge (2 with ACC_SEQ_AUTOCLR_EN), then one op per cycle.
// Backpressure: none; start and prog_we are dropped (not queued) while busy.
// Ports: clk, clr (synchronous active-high reset), bus (acc_sequencer_if.slave).
// Build option ACC_SEQ_AUTOCLR_EN: adds a one-cycle CLR state driving acc_clr_n low before each run.
module acc_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            clk,
    input  logic            clr,
    acc_sequencer_if.slave  bus
);

`ifdef ACC_SEQ_AUTOCLR_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_CLR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW:0]   r_len;
    logic [AW:0]   w_len_nxt;
    logic [3:0]    r_prog_a  [DEPTH];
    logic [3:0]    r_prog_op [DEPTH];

    logic [AW:0]   w_len_clamp;
    logic          w_last;
    logic [3:0]    w_op;
    logic          w_run;
    logic          w_issue;

    assign w_len_clamp = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;
    // pc is the index of the step being shown; the run ends after step len_q-1.
    assign w_last      = (({1'b0, r_pc} + (AW+1)'(1)) == r_len);
    assign w_op        = r_prog_op[r_pc];
    assign w_run       = (r_state == S_RUN);
    assign w_issue     = w_run && (w_op <= 4'd8);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_len_nxt   = r_len;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_len_nxt = w_len_clamp;
                    w_pc_nxt  = '0;
`ifdef ACC_SEQ_AUTOCLR_EN
                    w_state_nxt = S_CLR;
`else
                    w_state_nxt = (w_len_clamp == '0) ? S_DONE : S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_pc_nxt = r_pc + AW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
`ifdef ACC_SEQ_AUTOCLR_EN
            S_CLR: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = (r_len == '0) ? S_DONE : S_RUN;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // Program store: cleared to (a=0, NOP) on reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_prog_a[i]  <= 4'h0;
                r_prog_op[i] <= 4'hF;
            end
        end else if ((r_state == S_IDLE) && bus.prog_we) begin
            r_prog_a[bus.prog_addr]  <= bus.prog_a;
            r_prog_op[bus.prog_addr] <= bus.prog_op;
        end
    end

    // Outputs decode from registered state only, never from inputs.
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.pc     = r_pc;
    assign bus.acc_a  = w_run ? r_prog_a[r_pc] : 4'h0;
    assign bus.acc_in = w_issue ? (9'd1 << w_op) : 9'd0;
    assign bus.acc_en = w_issue;
`ifdef ACC_SEQ_AUTOCLR_EN
    assign bus.acc_clr_n = (r_state != S_CLR);
`endif

endmodule

// File: tb/tb_acc_sequencer.sv
// Purpose: randomized self-checking bench for acc_sequencer against a trace-level program model.
// Latency: expects the first op 1 cycle after start (2 with ACC_SEQ_AUTOCLR_EN).
// Backpressure: drives junk start/prog_we during runs and expects them to be ignored.
module tb_acc_sequencer;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk;
    logic clr;
    int   n_cmp;
    int   n_err;

    // Reference program contents
    logic [3:0] m_a  [DEPTH];
    logic [3:0] m_op [DEPTH];

    acc_sequencer_if #(.AW(AW)) bus ();

    acc_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_a[i]  = 4'h0;
            m_op[i] = 4'hF;
        end
    endtask

    task automatic write_entry(input int addr, input logic [3:0] a, input logic [3:0] op);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr[AW-1:0];
        bus.prog_a    = a;
        bus.prog_op   = op;
        tick();
        bus.prog_we   = 1'b0;
        m_a[addr]  = a;
        m_op[addr] = op;
    endtask

    task automatic exp_step(input int i);
        logic [8:0] e_in;
        e_in = (m_op[i] <= 4'd8) ? (9'd1 << m_op[i]) : 9'd0;
        @(negedge clk);
        chk("step_busy", bus.busy, 1);
        chk("step_done", bus.done, 0);
        chk("step_pc",   bus.pc, i);
        chk("step_a",    bus.acc_a, m_a[i]);
        chk("step_in",   bus.acc_in, e_in);
        chk("step_en",   bus.acc_en, (m_op[i] <= 4'd8) ? 1 : 0);
`ifdef ACC_SEQ_AUTOCLR_EN
        chk("step_clrn", bus.acc_clr_n, 1);
`endif
        tick();
    endtask

    task automatic exp_done();
        @(negedge clk);
        chk("done_done", bus.done, 1);
        chk("done_busy", bus.busy, 1);
        chk("done_en",   bus.acc_en, 0);
        chk("done_in",   bus.acc_in, 0);
        tick();
    endtask

    task automatic exp_idle();
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_en",   bus.acc_en, 0);
        chk("idle_in",   bus.acc_in, 0);
        tick();
    endtask

`ifdef ACC_SEQ_AUTOCLR_EN
    task automatic exp_clr();
        @(negedge clk);
        chk("clr_clrn", bus.acc_clr_n, 0);
        chk("clr_busy", bus.busy, 1);
        chk("clr_en",   bus.acc_en, 0);
        chk("clr_in",   bus.acc_in, 0);
        tick();
    endtask
`endif

    // One run: start with len, optionally abort while step abort_at is shown,
    // optionally toggle start/prog_we randomly while the sequencer is busy.
    task automatic run(input int len, input int abort_at, input bit junk);
        int  n;
        bit  aborted;
        n = (len > DEPTH) ? DEPTH : len;
        aborted = 1'b0;
        bus.start = 1'b1;
        bus.len   = len[AW:0];
        tick();
        bus.start = 1'b0;
`ifdef ACC_SEQ_AUTOCLR_EN
        exp_clr();
`endif
        for (int i = 0; i < n; i++) begin
            bus.abort = (i == abort_at);
            if (junk) begin
                bus.prog_we   = 1'($urandom % 2);
                bus.prog_addr = AW'($urandom);
                bus.prog_a    = 4'($urandom);
                bus.prog_op   = 4'($urandom);
                bus.start     = 1'($urandom % 2);
                bus.len       = (AW+1)'($urandom);
            end
            exp_step(i);
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        bus.abort   = 1'b0;
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
        if (!aborted) exp_done();
        exp_idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.prog_we = 0; bus.prog_addr = '0; bus.prog_a = '0; bus.prog_op = '0;
        bus.start = 0; bus.len = '0; bus.abort = 0;
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        model_clear();

        // Reset state
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pc",   bus.pc, 0);
        chk("rst_a",    bus.acc_a, 0);
        chk("rst_in",   bus.acc_in, 0);
        chk("rst_en",   bus.acc_en, 0);
`ifdef ACC_SEQ_AUTOCLR_EN
        chk("rst_clrn", bus.acc_clr_n, 1);
`endif
        tick();

        // Cleared program: every entry is a NOP with operand 0
        run(8, -1, 0);

        // Basic three-op program
        write_entry(0, 4'd3, 4'd0);
        write_entry(1, 4'hE, 4'd4);
        write_entry(2, 4'd1, 4'd8);
        run(3, -1, 0);
        run(3, -1, 0);                 // repeatable

        // NOP in the middle
        write_entry(1, 4'hE, 4'd12);
        run(3, -1, 0);

        // Zero-length run
        run(0, -1, 0);

        // Full program, abort at pc 3, junk writes/starts during run
        for (int i = 3; i < DEPTH; i++) write_entry(i, 4'($urandom), 4'($urandom_range(0, 8)));
        run(8, 3, 1);
        run(8, -1, 0);                 // program intact after junk
        run(13, -1, 0);                // len clamped to DEPTH

        // Start held high across DONE starts a second run
        bus.start = 1'b1;
        bus.len   = 4'd2;
        tick();
`ifdef ACC_SEQ_AUTOCLR_EN
        exp_clr();
`endif
        exp_step(0);
        exp_step(1);
        exp_done();
        exp_idle();
        bus.start = 1'b0;
`ifdef ACC_SEQ_AUTOCLR_EN
        exp_clr();
`endif
        exp_step(0);
        exp_step(1);
        exp_done();
        exp_idle();

        // clr mid-run at pc 2
        bus.start = 1'b1;
        bus.len   = 4'd8;
        tick();
        bus.start = 1'b0;
`ifdef ACC_SEQ_AUTOCLR_EN
        exp_clr();
`endif
        exp_step(0);
        exp_step(1);
        clr = 1'b1;
        exp_step(2);
        clr = 1'b0;
        model_clear();
        exp_idle();
        run(1, -1, 0);                 // program was cleared: NOP

        // Randomized runs
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                write_entry($urandom_range(0, DEPTH - 1), 4'($urandom), 4'($urandom));
            run($urandom_range(0, 15),
                ($urandom % 4 == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1,
                1'($urandom % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
